// File: rtl/data_pipe_pkg.sv
// Shared constants and helpers for the data_pipe pipeline.
package data_pipe_pkg;

    // Largest supported stage count.
    localparam int unsigned DEPTH_MAX = 16;

    // Width of the output transfer counter.
    localparam int unsigned CNT_W = 32;

    // Bits needed to count 0..depth occupied stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_pipe_stage.sv
// One valid/data register slice of data_pipe.
// - The valid bit follows the upstream valid whenever load is high.
// - The data register captures only when a valid word arrives.
// - clr empties the slice and leaves its data untouched.
module data_pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] prev_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Valid bit: flush wins over a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= prev_valid;
        end
    end

    // Payload: an empty slot moving in keeps the stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load && prev_valid && !clr) begin
            data_q <= prev_data;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/data_pipe.sv
// data_pipe: DEPTH-stage valid/ready pipeline with bubble collapsing and a
// synchronous flush. Optional macro DATA_PIPE_CNT_EN adds the occupancy and
// xfer_cnt status outputs.
// out_ready reaches in_ready combinationally through the advance chain; there
// is no skid buffer.
module data_pipe
    import data_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready
`ifdef DATA_PIPE_CNT_EN
    ,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic [CNT_W-1:0]             xfer_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("data_pipe: DEPTH out of range");
    end

    // adv[i]: stage i may take a new value this cycle.
    logic [DEPTH:0]    adv;
    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];

    // Advance chain from the consumer back to the producer.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i] = !v[i] || adv[i+1];
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar j = 0; j < DEPTH; j++) begin : g_stage
        logic              prev_valid;
        logic [DATA_W-1:0] prev_data;

        if (j == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_body
            assign prev_valid = v[j-1];
            assign prev_data  = d[j-1];
        end

        data_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (flush),
            .load       (adv[j]),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .valid      (v[j]),
            .data       (d[j])
        );
    end

`ifdef DATA_PIPE_CNT_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [CNT_W-1:0] xfer_cnt_q;

    // Population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    // Output transfers since reset; flush does not clear it, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_data_pipe.sv
// Scoreboard bench for data_pipe. Inputs change on the falling edge; the
// monitor looks at the DUT 3 units later and the driver 4 units later, both
// ahead of the next rising edge.
module tb_data_pipe;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
`ifdef DATA_PIPE_CNT_EN
    logic [2:0]        occupancy;
    logic [31:0]       xfer_cnt;
`endif

    data_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DATA_PIPE_CNT_EN
        ,
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: words accepted but not yet delivered, oldest first.
    logic [DATA_W-1:0] exp_q[$];

    int win = 0;             // index of the sampling window before each rising edge
    int out_total = 0;       // words delivered since last reset
    int acc_cnt = 0;         // words accepted (random phase)
    logic lat_arm = 1'b0;
    int first_acc_win = -1;
    int first_out_win = -1;
    int last_out_win = -1;
    logic stall_hold = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    always @(posedge clk) win <= win + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
`ifdef DATA_PIPE_CNT_EN
                check("occupancy", 64'(occupancy), 64'(exp_q.size()));
                check("xfer_cnt", 64'(xfer_cnt), 64'(out_total));
`endif
                if (stall_hold) check("stall_stable", {out_valid, out_data}, {1'b1, stall_data});
                if (lat_arm && out_valid && first_out_win < 0) first_out_win = win;
                if (exp_q.size() == 0) begin
                    check("out_valid_when_empty", 64'(out_valid), 64'd0);
                end else if (out_valid && out_ready) begin
                    check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    out_total++;
                    last_out_win = win;
                end
                stall_hold = out_valid && !out_ready && !flush;
                stall_data = out_data;
            end else begin
                stall_hold = 1'b0;
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance from occupancy alone.
    task automatic step(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                        input logic fl);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #4;
        if (rst_n) begin
            // A word popped this window implies ordy = 1, so size is still safe to use.
            exp_rdy = ((exp_q.size() < DEPTH) || ordy) && !fl;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (iv && exp_rdy) begin
                exp_q.push_back(id);
                acc_cnt++;
                if (lat_arm && first_acc_win < 0) first_acc_win = win;
            end
            if (fl) exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check("reset_async_out_valid", 64'(out_valid), 64'd0);
        check("reset_async_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        out_total = 0;
        repeat (3) @(negedge clk);
        check("reset_hold_out_valid", 64'(out_valid), 64'd0);
        check("reset_hold_out_data", 64'(out_data), 64'd0);
`ifdef DATA_PIPE_CNT_EN
        check("reset_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
    endtask

    initial begin
        do_reset();

        // Streaming: latency DEPTH windows, then one word per cycle.
        lat_arm = 1'b1;
        for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);
        lat_arm = 1'b0;
        check("stream_latency", 64'(first_out_win - first_acc_win), 64'(DEPTH));
        check("stream_throughput", 64'(last_out_win - first_out_win), 64'd7);
        check("stream_count", 64'(out_total), 64'd8);

        // Backpressure: fill, hold, release.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + DATA_W'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            step(1'b0, '0, 1'b0, 1'b0);
            check("bp_hold_data", 64'(out_data), 64'h10);
        end
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_count", 64'(out_total), 64'd12);

        // Bubble collapse with the consumer stalled.
        step(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("bubble_not_yet", 64'(out_valid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("bubble_arrived", {out_valid, out_data}, {1'b1, 8'h55});
        step(1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
`ifdef DATA_PIPE_CNT_EN
        check("bubble_occupancy", 64'(occupancy), 64'd2);
`endif
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        check("bubble_drained", 64'(exp_q.size()), 64'd0);

        // Flush with input offered: nothing accepted, pipe empty afterwards.
        for (int i = 1; i <= 3; i++) step(1'b1, 8'hA0 + DATA_W'(i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Flush while the output word is consumed.
        repeat (DEPTH + 1) step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_consume_empty", 64'(out_valid), 64'd0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + DATA_W'(i), 1'b0, 1'b0);
        do_reset();
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);
        check("midreset_nothing_out", 64'(out_total), 64'd0);

        // Random traffic, 1000 words.
        do_reset();
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            logic iv;
            logic ordy;
            iv   = ($urandom_range(9) < 7);
            ordy = ($urandom_range(9) < 6);
            step(iv, DATA_W'($urandom), ordy, 1'b0);
        end
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("rand_accepted", 64'(acc_cnt), 64'd1000);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_delivered", 64'(out_total), 64'd1000);
`ifdef DATA_PIPE_CNT_EN
        check("rand_xfer_cnt", 64'(xfer_cnt), 64'd1000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
